// File: rtl/sram_mem_ctrl.sv
// MEM-stage responder: splits each 32-bit load/store into two 16-bit SRAM phases.
// Optional SRAM_ADDR_CHECK_EN: out-of-range requests complete at once with addr_err set.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_W      = 18,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              addr_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, err_q;
  logic [31:0]      read_data_q;

  logic        req, last, oor;
  logic [31:0] offs;
  logic [30:0] hw_full;

  assign req     = rd_en | wr_en;
  assign last    = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign offs    = address - 32'(BASE_ADDR);
  assign hw_full = {offs[31:2], (state_q == HI)};

`ifdef SRAM_ADDR_CHECK_EN
  assign oor = (address < 32'(BASE_ADDR)) ||
               ({2'b00, offs[31:2]} >= (32'd1 << (ADDR_W - 1)));
`else
  assign oor = 1'b0;
`endif

  // Address LSBs and wrapped-off upper half-word bits are intentionally dropped.
  logic unused;
  assign unused = ^{offs[1:0], hw_full[30:ADDR_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= (state_q == IDLE) && req && oor;
      if (state_q == IDLE && req) wr_q <= wr_en;
      if (state_q == IDLE && req && oor && !wr_en) read_data_q <= '0;
      if (state_q == LO && last && !wr_q) read_data_q[15:0]  <= sram_dq_i;
      if (state_q == HI && last && !wr_q) read_data_q[31:16] <= sram_dq_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) state_d = oor ? DONE : LO;
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_ce_n  = 1'b1;
    case (state_q)
      IDLE: ready = ~req;
      LO, HI: begin
        sram_ce_n = 1'b0;
        sram_addr = hw_full[ADDR_W-1:0];
        if (wr_q) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
          sram_dq_o  = (state_q == HI) ? write_data[31:16] : write_data[15:0];
        end else sram_oe_n = 1'b0;
      end
      default: ready = 1'b1;
    endcase
  end

  assign read_data = read_data_q;
  assign addr_err  = err_q;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small behavioural SRAM model.
module tb_sram_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, addr_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc;

  logic [15:0] mem [64];
  logic        pre_en;
  logic [5:0]  pre_a;
  logic [15:0] pre_d;

  logic [17:0] a_l  [40];
  logic [15:0] dq_l [40];
  logic        ce_l [40], we_l [40], oe_l [40], dqoe_l [40], err_l [40];

  always #5 clk = ~clk;

  sram_mem_ctrl #(.WAIT_CYCLES(5), .ADDR_W(18), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .addr_err(addr_err),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n)
  );

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq_o;
  end
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request (called #1 after a rising edge) and log outputs each cycle until ready.
  task automatic run(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd_en = r; wr_en = w; address = a; write_data = d;
    n_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a_l[k] = sram_addr; dq_l[k] = sram_dq_o; ce_l[k] = sram_ce_n; we_l[k] = sram_we_n;
      oe_l[k] = sram_oe_n; dqoe_l[k] = sram_dq_oe; err_l[k] = addr_err;
      if (ready) begin
        n_cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_access(input logic w, input logic [17:0] hw0, input logic [31:0] d);
    chk("latency", n_cyc, 32'd11);
    if (n_cyc != 11) return;
    for (int k = 0; k <= 11; k++) begin
      logic act, hi;
      act = (k >= 1) && (k <= 10);
      hi  = (k >= 6);
      chk("ce_n", 32'(ce_l[k]), 32'(!act));
      chk("we_n", 32'(we_l[k]), 32'(!(act && w)));
      chk("oe_n", 32'(oe_l[k]), 32'(!(act && !w)));
      chk("dq_oe", 32'(dqoe_l[k]), 32'(act && w));
      if (act) chk("sram_addr", 32'(a_l[k]), 32'(hw0) + 32'(hi));
      if (act && w) chk("dq_o", 32'(dq_l[k]), hi ? 32'(d[31:16]) : 32'(d[15:0]));
    end
  endtask

  task automatic idle_cycle;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);

    pre_en = 1'b1; pre_a = 6'd4; pre_d = 16'h5678;
    @(posedge clk); #1;
    pre_a = 6'd5; pre_d = 16'h1234;
    @(posedge clk); #1;
    pre_en = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Store to half-words 0/1
    run(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    check_access(1'b1, 18'd0, 32'hDEADBEEF);
    chk("wr_rdata", read_data, 32'd0);
    idle_cycle();
    chk("mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[1]), 32'h0000DEAD);

    // Load from half-words 4/5
    run(1'b1, 1'b0, 32'd1032, 32'h0);
    check_access(1'b0, 18'd4, 32'h0);
    chk("rd_data", read_data, 32'h12345678);
    chk("rd_err", 32'(err_l[11]), 32'd0);
    idle_cycle();

    // Both enables -> write to half-words 2/3, read_data untouched
    run(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
    check_access(1'b1, 18'd2, 32'hCAFEF00D);
    chk("both_rdata", read_data, 32'h12345678);
    idle_cycle();
    chk("mem2", 32'(mem[2]), 32'h0000F00D);
    chk("mem3", 32'(mem[3]), 32'h0000CAFE);

    // Back-to-back store then load, no idle gap between requests
    run(1'b0, 1'b1, 32'd1040, 32'hA5A55A5A);
    check_access(1'b1, 18'd8, 32'hA5A55A5A);
    @(posedge clk); #1;
    run(1'b1, 1'b0, 32'd1040, 32'h0);
    check_access(1'b0, 18'd8, 32'h0);
    chk("b2b_rdata", read_data, 32'hA5A55A5A);
    idle_cycle();

`ifdef SRAM_ADDR_CHECK_EN
    run(1'b1, 1'b0, 32'h10, 32'h0);
    chk("oor_latency", n_cyc, 32'd1);
    chk("oor_err", 32'(err_l[1]), 32'd1);
    chk("oor_ce0", 32'(ce_l[0]), 32'd1);
    chk("oor_ce1", 32'(ce_l[1]), 32'd1);
    chk("oor_rdata", read_data, 32'd0);
    idle_cycle();
    @(negedge clk);
    chk("oor_err_clr", 32'(addr_err), 32'd0);
    @(posedge clk); #1;
`endif

    // Reset during HI of a write
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1048; write_data = 32'h11112222;
    repeat (7) @(posedge clk); #1;
    chk("pre_rst_ce", 32'(sram_ce_n), 32'd0);
    chk("pre_rst_addr", 32'(sram_addr), 32'd13);
    rst = 1'b1; #1;
    chk("mid_rst_ce", 32'(sram_ce_n), 32'd1);
    chk("mid_rst_we", 32'(sram_we_n), 32'd1);
    chk("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    wr_en = 1'b0; #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_rdata", read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-side responder for the load/store requests issued by the execute stage: address = ALU result, write data = forwarded Rm value, plus mem_R_en/mem_W_en.
- Converts each 32-bit word access into two 16-bit external SRAM accesses (low half, then high half), each held for a fixed number of wait cycles.
- Drives ready low while an access is in flight so the hazard/freeze logic stalls the pipeline; sits in the MEM stage between the EX/MEM register and the board SRAM.

Parameters:
- WAIT_CYCLES, 5, cycles per 16-bit SRAM phase; legal range >= 1.
- ADDR_W, 18, SRAM half-word address width.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM half-word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  load request (mem_R_en from EX/MEM); held stable while ready=0.
- wr_en  input  1  store request (mem_W_en from EX/MEM); held stable while ready=0.
- address  input  32  CPU byte address (ALU result).
- write_data  input  32  store data (forwarded Rm value).
- read_data  output  32  registered load result.
- ready  output  1  1 = no stall; 0 = freeze pipeline.
- addr_err  output  1  out-of-range flag (see Optional Feature).
- sram_addr  output  ADDR_W  SRAM half-word address.
- sram_dq_o  output  16  data to SRAM.
- sram_dq_i  input  16  data from SRAM.
- sram_dq_oe  output  1  1 = drive the SRAM data bus.
- sram_we_n  output  1  SRAM write enable, active low.
- sram_oe_n  output  1  SRAM output enable, active low.
- sram_ce_n  output  1  SRAM chip enable, active low.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=sram_oe_n=sram_ce_n=1, addr_err=0. A reset during an access abandons it; no partial write is retried.
- Address map: word = (address - BASE_ADDR) >> 2. Low phase uses sram_addr = {word, 0}; high phase uses {word, 1}; both truncated to ADDR_W (wraps). address[1:0] is ignored.
- Request priority: if rd_en and wr_en are both 1, the access is treated as a write.
- States: IDLE, LO, HI, DONE.
  - IDLE -> LO when (rd_en | wr_en); counter cleared.
  - LO: counter increments each cycle; at counter == WAIT_CYCLES-1 -> HI, counter cleared.
  - HI: same counting rule; at WAIT_CYCLES-1 -> DONE.
  - DONE -> IDLE unconditionally, after exactly one cycle.
- ready (combinational):
  - IDLE: ~(rd_en | wr_en).
  - LO, HI: 0.
  - DONE: 1.
- Latency: request first seen in cycle 0 (IDLE); ready is 0 in cycles 0..2*WAIT_CYCLES and 1 in cycle 2*WAIT_CYCLES+1 (DONE). With WAIT_CYCLES=5, ready=1 in cycle 11.
- SRAM strobes during LO/HI:
  - sram_ce_n = 0 in both.
  - Write: sram_we_n = 0, sram_dq_oe = 1, sram_dq_o = write_data[15:0] in LO, write_data[31:16] in HI; sram_oe_n = 1.
  - Read: sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - IDLE/DONE: all strobes inactive, sram_dq_oe = 0.
- Read capture: sram_dq_i is sampled into read_data[15:0] on the last LO cycle and into read_data[31:16] on the last HI cycle. read_data holds its value until the next read overwrites it; writes never change it.
- Back-to-back: a new request present in the cycle after DONE starts a fresh access from IDLE; there is no pipelining across accesses.

Optional Feature:
- Macro: SRAM_ADDR_CHECK_EN.
- Defined:
  - In IDLE, a request with address < BASE_ADDR or word >= 2^(ADDR_W-1) goes directly to DONE; addr_err = 1 during that DONE cycle.
  - No SRAM strobes are issued, and read_data is set to 0 for reads.
  - ready is 0 in cycle 0 and 1 in cycle 1.
- Undefined: addr_err is tied to 0 and out-of-range addresses wrap as described in Behaviour.

Test Plan:
- Reset mid-access: assert rst during HI of a write -> all strobes inactive immediately, ready=1 with no request, read_data=0.
- Write: address=1024, write_data=0xDEADBEEF, wr_en=1, WAIT=5 -> sram_addr=0 with dq_o=0xBEEF and we_n=0 for 5 cycles; then sram_addr=1 with dq_o=0xDEAD for 5 cycles; ready=1 in cycle 11.
- Read: address=1032, rd_en=1, model returns 0x5678 at half-word 4 and 0x1234 at half-word 5 -> read_data=0x12345678 when ready rises in cycle 11; sram_oe_n=0 throughout, dq_oe=0.
- Both rd_en and wr_en set with address=1028 -> write behaviour (we_n=0, half-words 2 and 3); read_data unchanged from the previous value.
- Back-to-back: store then load to the same address, each held until ready -> load returns the stored word; ready is 1 for exactly one cycle between the two accesses.
- With SRAM_ADDR_CHECK_EN, rd_en=1 and address=0x10 -> addr_err=1 and ready=1 in cycle 1, read_data=0, sram_ce_n stays 1.
